// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_pkg
//  Purpose  : Shared types and constants for the keypad capture block:
//             FSM state encoding, the 4x4 keypad keymap and the default
//             timing parameters.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package key_pkg;

   // Capture FSM states, explicitly 2 bits wide.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   localparam logic [15:0] c_DB_CYCLES_DEFAULT  = 16'd50000;
   localparam logic [15:0] c_MUX_CYCLES_DEFAULT = 16'd10000;

   // Keymap indexed by {row_idx, col_idx}, row1/col1 = index 0.
   // Entry 0 (rightmost) is row1/col1 = '1', entry 15 is row4/col4 = 'D'.
   localparam logic [15:0][3:0] c_KEYMAP = {
      4'hD, 4'hF, 4'h0, 4'hE,   // row4
      4'hC, 4'h9, 4'h8, 4'h7,   // row3
      4'hB, 4'h6, 4'h5, 4'h4,   // row2
      4'hA, 4'h3, 4'h2, 4'h1    // row1
   };

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_decode.sv
`default_nettype none
// ============================================================================
//  Module   : key_decode
//  Purpose  : Purely combinational keypad code decoder.
//  Ports    : total_val [7:0] in  - {rows one-hot high (bit7=row1),
//                                    cols one-cold low (bit3=col1)}
//             valid         out - exactly one row high and one column low
//             hex     [3:0] out - keymap value (0 when not valid)
//  Revision : 1.0  initial release
// ============================================================================
module key_decode
   import key_pkg::*;
(
   input  logic [7:0] total_val,
   output logic       valid,
   output logic [3:0] hex
);

   logic [1:0] w_row_idx;
   logic [1:0] w_col_idx;
   logic       w_row_ok;
   logic       w_col_ok;

   // Row bits are active-high with row1 in the MSB.
   always_comb begin
      w_row_idx = 2'd0;
      w_row_ok  = 1'b1;
      case (total_val[7:4])
         4'b1000: w_row_idx = 2'd0;
         4'b0100: w_row_idx = 2'd1;
         4'b0010: w_row_idx = 2'd2;
         4'b0001: w_row_idx = 2'd3;
         default: w_row_ok  = 1'b0;
      endcase
   end

   // Column bits are active-low with col1 in the MSB.
   always_comb begin
      w_col_idx = 2'd0;
      w_col_ok  = 1'b1;
      case (total_val[3:0])
         4'b0111: w_col_idx = 2'd0;
         4'b1011: w_col_idx = 2'd1;
         4'b1101: w_col_idx = 2'd2;
         4'b1110: w_col_idx = 2'd3;
         default: w_col_ok  = 1'b0;
      endcase
   end

   assign valid = w_row_ok & w_col_ok;
   assign hex   = valid ? c_KEYMAP[{w_row_idx, w_col_idx}] : 4'h0;

endmodule : key_decode
`default_nettype wire

// File: rtl/key_capture.sv
`default_nettype none
// ============================================================================
//  Module   : key_capture
//  Purpose  : Debounced keypad capture with a two-digit history and a
//             free-running display multiplexer.
//  Ports    : clk             in  - system clock, rising edge
//             reset           in  - asynchronous, active-low
//             enable          in  - scanner strobe: candidate on total_val
//             key_pressed     in  - high while any column is active
//             total_val [7:0] in  - {rows one-hot, cols active-low}
//             key_valid       out - one-cycle pulse per accepted key
//             digit_new [3:0] out - most recent accepted key
//             digit_old [3:0] out - previous accepted key
//             disp_sel        out - 0 shows digit_new, 1 shows digit_old
//             disp_digit[3:0] out - currently selected digit
//  Revision : 1.0  initial release
// ============================================================================
module key_capture
   import key_pkg::*;
#(
   parameter logic [15:0] DB_CYCLES  = c_DB_CYCLES_DEFAULT,
   parameter logic [15:0] MUX_CYCLES = c_MUX_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       key_pressed,
   input  logic [7:0] total_val,
   output logic       key_valid,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old,
   output logic       disp_sel,
   output logic [3:0] disp_digit
);

   localparam logic [15:0] c_DB_LAST  = DB_CYCLES  - 16'd1;
   localparam logic [15:0] c_MUX_LAST = MUX_CYCLES - 16'd1;

   state_t      r_state;
   state_t      w_next_state;
   logic [7:0]  r_code;
   logic [15:0] r_db_cnt;
   logic [15:0] r_mux_cnt;
   logic        r_disp_sel;
   logic [3:0]  r_digit_new;
   logic [3:0]  r_digit_old;
   logic        r_key_valid;

   logic        w_dec_valid;
   logic [3:0]  w_dec_hex;
   logic        w_stable;
   logic        w_db_done;
   logic        w_latch;
   logic        w_cnt_clr;
   logic        w_cnt_inc;
   logic        w_accept;

   key_decode u_decode (
      .total_val (total_val),
      .valid     (w_dec_valid),
      .hex       (w_dec_hex)
   );

   // Key still down and unchanged since it was latched.
   assign w_stable  = key_pressed && (total_val == r_code);
   assign w_db_done = (r_db_cnt == c_DB_LAST);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:     if (enable && w_dec_valid) w_next_state = DEBOUNCE;
         DEBOUNCE: if (!w_stable)             w_next_state = IDLE;
                   else if (w_db_done)        w_next_state = HELD;
         HELD:     if (!key_pressed)          w_next_state = RELEASE;
         RELEASE:  if (key_pressed)           w_next_state = HELD;
                   else if (w_db_done)        w_next_state = IDLE;
         default:                             w_next_state = IDLE;
      endcase
   end

   // ------------------------------------------------------ output controls
   always_comb begin
      w_latch   = 1'b0;
      w_cnt_clr = 1'b0;
      w_cnt_inc = 1'b0;
      w_accept  = 1'b0;
      case (r_state)
         IDLE: begin
            w_latch   = enable && w_dec_valid;
            w_cnt_clr = enable && w_dec_valid;
         end
         DEBOUNCE: begin
            w_cnt_inc = w_stable;
            w_accept  = w_stable && w_db_done;
         end
         HELD:    w_cnt_clr = !key_pressed;
         RELEASE: w_cnt_inc = !key_pressed;
         default: ;
      endcase
   end

   // Debounce counter saturates so a stuck count can never wrap back into
   // a spurious match.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_db_cnt <= 16'd0;
      end else if (w_cnt_clr) begin
         r_db_cnt <= 16'd0;
      end else if (w_cnt_inc && (r_db_cnt != 16'hFFFF)) begin
         r_db_cnt <= r_db_cnt + 16'd1;
      end
   end

   // On acceptance total_val still equals the latched code, so the single
   // decoder output is the accepted key.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_code      <= 8'd0;
         r_digit_new <= 4'd0;
         r_digit_old <= 4'd0;
         r_key_valid <= 1'b0;
      end else begin
         r_key_valid <= w_accept;
         if (w_latch) r_code <= total_val;
         if (w_accept) begin
            r_digit_old <= r_digit_new;
            r_digit_new <= w_dec_hex;
         end
      end
   end

   // Free-running display multiplexer, independent of the FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mux_cnt  <= 16'd0;
         r_disp_sel <= 1'b0;
      end else if (r_mux_cnt == c_MUX_LAST) begin
         r_mux_cnt  <= 16'd0;
         r_disp_sel <= ~r_disp_sel;
      end else begin
         r_mux_cnt  <= r_mux_cnt + 16'd1;
      end
   end

   assign key_valid  = r_key_valid;
   assign digit_new  = r_digit_new;
   assign digit_old  = r_digit_old;
   assign disp_sel   = r_disp_sel;
   assign disp_digit = r_disp_sel ? r_digit_old : r_digit_new;

endmodule : key_capture
`default_nettype wire

// File: doc/key_capture.md
KEY_CAPTURE -- requirements
Module: key_capture

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16'd50000, the debounce hold time in clk cycles; legal range 2..65535.
REQ-002 SHALL have parameter MUX_CYCLES, default 16'd10000, the display-multiplex half-period in clk cycles; legal range 2..65535.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  one-cycle strobe: the scanner has a candidate key on total_val.
REQ-006 SHALL have port key_pressed  input  1  high while any column is active.
REQ-007 SHALL have port total_val  input  8  {rows[3:0] one-hot active-high (bit3=row1), columns[3:0] active-low (bit3=col1)}.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a debounced key is accepted.
REQ-009 SHALL have port digit_new  output  4  hex value of the most recent accepted key.
REQ-010 SHALL have port digit_old  output  4  hex value of the previous accepted key.
REQ-011 SHALL have port disp_sel  output  1  display select: 0 = digit_new shown, 1 = digit_old shown.
REQ-012 SHALL have port disp_digit  output  4  digit_new when disp_sel=0, else digit_old.

Function
REQ-013 SHALL decode with this keymap: row1 = 1,2,3,A; row2 = 4,5,6,B; row3 = 7,8,9,C; row4 = E,0,F,D (col1..col4).
REQ-014 SHALL treat a code as valid only if exactly one row bit is high and exactly one column bit is low.
REQ-015 SHALL implement FSM states IDLE, DEBOUNCE, HELD, RELEASE.
REQ-016 IDLE: on enable=1 with a valid total_val, SHALL latch total_val, clear the counter and go to DEBOUNCE; otherwise it stays in IDLE.
REQ-017 DEBOUNCE: SHALL return to IDLE in any cycle where key_pressed=0 or total_val differs from the latched code.
REQ-018 DEBOUNCE: otherwise SHALL increment the counter; on the cycle the counter equals DB_CYCLES-1 it goes to HELD.
REQ-019 On the DEBOUNCE->HELD transition, SHALL register digit_old<=digit_new and digit_new<=decoded key, and pulse key_valid=1 for exactly one cycle.
REQ-020 HELD: SHALL stay while key_pressed=1, ignoring enable and total_val; on key_pressed=0 it clears the counter and goes to RELEASE.
REQ-021 RELEASE: on key_pressed=1 SHALL return to HELD (release bounce) with no new key_valid; otherwise it counts and goes to IDLE when the counter equals DB_CYCLES-1.
REQ-022 SHALL guarantee a held key produces exactly one key_valid, regardless of hold length.
REQ-023 SHALL ignore a second key pressed while in HELD; a key is accepted only after RELEASE completes and IDLE is re-entered.
REQ-024 SHALL use an independent free-running mux counter that toggles disp_sel when it reaches MUX_CYCLES-1 and wraps to 0.
REQ-025 SHALL produce disp_digit combinationally from disp_sel and the digit registers.
REQ-026 SHALL make the debounce counter 16 bits, saturating; it never wraps.

Reset
REQ-027 SHALL, while reset=0, asynchronously force: state=IDLE, both counters=0, digit_new=0, digit_old=0, key_valid=0, disp_sel=0.
REQ-028 SHALL abandon an in-progress debounce on reset assertion mid-operation, with no key_valid pulse and unchanged-from-reset digits.
REQ-029 SHALL resume in IDLE on the first rising clk edge after reset deasserts.

Structure
REQ-030 SHALL place the FSM state enum, the 16-entry keymap constant and the default parameter values in shared package key_pkg.
REQ-031 SHALL implement the decode as sub-module key_decode (total_val -> {valid, hex[3:0]}, purely combinational); key_capture instantiates it once.

Verification (DB_CYCLES=4, MUX_CYCLES=3)
REQ-032 SHALL cover: enable with 8'b1000_0111, key_pressed held 10 cycles -> key_valid pulses once, 4 cycles after enable, digit_new=1, digit_old=0.
REQ-033 SHALL cover: keys 5 (8'b0100_1011) then D (8'b0001_1110), each pressed and released -> digit_new=D, digit_old=5, two key_valid pulses.
REQ-034 SHALL cover: key_pressed dropping at the 2nd DEBOUNCE cycle -> no key_valid, digits unchanged, state IDLE.
REQ-035 SHALL cover: a 1-cycle release glitch in HELD, then a 20-cycle hold -> exactly one key_valid in total.
REQ-036 SHALL cover: invalid code 8'b1100_0111 with enable -> state remains IDLE, no key_valid.
REQ-037 SHALL cover: reset pulsed low mid-DEBOUNCE -> all outputs 0 immediately (async), with disp_sel toggling every 3 cycles afterward.
